// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl - multi-cycle control sequencer for the TinyRisc-V core.
//
// Steps each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and
// drives the datapath strobes. Instruction and data memory handshakes are
// bounded by MEM_TIMEOUT cycles. An unknown opcode or a memory timeout parks
// the sequencer in HALT until reset.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   run                 allows a new fetch to start (sampled in FETCH only)
//   opcode, wb_reg      fields of the latched instruction from decode
//   imem_req/imem_ack   instruction memory handshake
//   ir_we               load instruction register
//   dmem_req/dmem_we    data memory request / store qualifier
//   dmem_ack            data memory completion
//   pc_we, reg_we       commit next PC, register-file write
//   retired             retired instruction count (wraps)
//   illegal, bus_err    sticky fault flags
//   state               current state (debug)
module core_seq_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [6:0]           opcode,
    input  logic                 wb_reg,
    output logic                 imem_req,
    input  logic                 imem_ack,
    output logic                 ir_we,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    output logic                 pc_we,
    output logic                 reg_we,
    output logic [CNT_WIDTH-1:0] retired,
    output logic                 illegal,
    output logic                 bus_err,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam int              TW      = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0]   TO_LAST = TW'(MEM_TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [TW-1:0]          wcnt_q, wcnt_d;
    logic [CNT_WIDTH-1:0]   retired_q, retired_d;
    logic                   illegal_q, illegal_d;
    logic                   bus_err_q, bus_err_d;

    logic is_load, is_store, is_branch, is_legal;

    always_comb begin
        is_load   = (opcode == OP_LOAD);
        is_store  = (opcode == OP_STORE);
        is_branch = (opcode == OP_BRANCH);
        is_legal  = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_REG: is_legal = 1'b1;
            default:                           is_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = '0;           // clears on ack, state exit and idle
        retired_d = retired_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = run;
                if (run) begin
                    if (imem_ack) begin
                        ir_we   = 1'b1;
                        state_d = S_DECODE;
                    end else if (wcnt_q == TO_LAST) begin
                        bus_err_d = 1'b1;
                        state_d   = S_HALT;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXEC: begin
                if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_branch) begin
                    pc_we     = 1'b1;
                    retired_d = retired_q + 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ack) begin
                    if (is_store) begin
                        // Stores have nothing to write back: retire here.
                        pc_we     = 1'b1;
                        retired_d = retired_q + 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wcnt_q == TO_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_WB: begin
                reg_we    = wb_reg;
                pc_we     = 1'b1;
                retired_d = retired_q + 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: ;
            default: state_d = S_HALT;
        endcase

        // Reset kills any in-flight request in the same cycle.
        if (rst) begin
            imem_req = 1'b0;
            ir_we    = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            pc_we    = 1'b0;
            reg_we   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wcnt_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign retired = retired_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed, table-driven bench for core_seq_ctrl (MEM_TIMEOUT=4).
// Each row is one clock cycle: inputs driven at negedge, outputs checked
// 1ns later (before the next posedge).
module tb_core_seq_ctrl;

    localparam int MT = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic [6:0]    opcode = '0;
    logic          wb_reg = 1'b0;
    logic          imem_ack = 1'b0;
    logic          dmem_ack = 1'b0;
    logic          imem_req, ir_we, dmem_req, dmem_we, pc_we, reg_we;
    logic          illegal, bus_err;
    logic [CW-1:0] retired;
    logic [2:0]    state;

    always #5 clk = ~clk;

    core_seq_ctrl #(.MEM_TIMEOUT(MT), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .wb_reg(wb_reg),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .pc_we(pc_we), .reg_we(reg_we), .retired(retired),
        .illegal(illegal), .bus_err(bus_err), .state(state)
    );

    typedef struct packed {
        logic       rst, run;
        logic [6:0] op;
        logic       wb, ia, da;
    } in_t;

    typedef struct packed {
        logic [2:0]  st;
        logic        ireq, irwe, dreq, dwe, pcwe, rwe, ill, berr;
        logic [31:0] ret;
    } out_t;

    typedef struct {
        in_t   i;
        out_t  o;
        string nm;
    } vec_t;

    localparam logic [6:0] ALU = 7'b0010011, LUI = 7'b0110111, LD = 7'b0000011,
                           ST  = 7'b0100011, BR  = 7'b1100011, BAD = 7'b1111111;

    int n_chk  = 0;
    int n_fail = 0;
    vec_t tbl[$];

    function automatic in_t vi(int r, int rn, logic [6:0] op, int wb, int ia, int da);
        in_t v;
        v.rst = 1'(r); v.run = 1'(rn); v.op = op; v.wb = 1'(wb); v.ia = 1'(ia); v.da = 1'(da);
        return v;
    endfunction

    function automatic out_t vo(int st, int ireq, int irwe, int dreq, int dwe,
                                int pcwe, int rwe, int ill, int berr, int ret);
        out_t v;
        v.st = 3'(st); v.ireq = 1'(ireq); v.irwe = 1'(irwe); v.dreq = 1'(dreq);
        v.dwe = 1'(dwe); v.pcwe = 1'(pcwe); v.rwe = 1'(rwe); v.ill = 1'(ill);
        v.berr = 1'(berr); v.ret = 32'(ret);
        return v;
    endfunction

    function automatic void add(string nm, in_t i, out_t o);
        vec_t v;
        v.nm = nm; v.i = i; v.o = o;
        tbl.push_back(v);
    endfunction

    task automatic step(input string nm, input in_t i, input out_t e);
        out_t a;
        @(negedge clk);
        rst = i.rst; run = i.run; opcode = i.op; wb_reg = i.wb;
        imem_ack = i.ia; dmem_ack = i.da;
        #1;
        a.st = state; a.ireq = imem_req; a.irwe = ir_we; a.dreq = dmem_req;
        a.dwe = dmem_we; a.pcwe = pc_we; a.rwe = reg_we; a.ill = illegal;
        a.berr = bus_err; a.ret = retired;
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got st=%0d ireq=%b irwe=%b dreq=%b dwe=%b pcwe=%b rwe=%b ill=%b berr=%b ret=%0d, required st=%0d ireq=%b irwe=%b dreq=%b dwe=%b pcwe=%b rwe=%b ill=%b berr=%b ret=%0d",
                     nm, a.st, a.ireq, a.irwe, a.dreq, a.dwe, a.pcwe, a.rwe, a.ill, a.berr, a.ret,
                     e.st, e.ireq, e.irwe, e.dreq, e.dwe, e.pcwe, e.rwe, e.ill, e.berr, e.ret);
        end
    endtask

    initial begin
        //            rst run op   wb ia da        st ir iw dr dw pc rw il be ret
        add("reset",  vi(1, 0, ALU, 1, 0, 0), vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // ALU op, 4 cycles
        add("alu_f",  vi(0, 1, ALU, 1, 1, 0), vo(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        add("alu_d",  vi(0, 1, ALU, 1, 1, 0), vo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("alu_e",  vi(0, 1, ALU, 1, 1, 0), vo(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("alu_w",  vi(0, 1, ALU, 1, 1, 0), vo(4, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        add("alu_r",  vi(0, 0, ALU, 1, 0, 0), vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        // Load with 3-cycle dmem delay, 8 cycles
        add("ld_f",   vi(0, 1, LD,  1, 1, 0), vo(0, 1, 1, 0, 0, 0, 0, 0, 0, 1));
        add("ld_d",   vi(0, 1, LD,  1, 0, 0), vo(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        add("ld_e",   vi(0, 1, LD,  1, 0, 0), vo(2, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        add("ld_m0",  vi(0, 1, LD,  1, 0, 0), vo(3, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        add("ld_m1",  vi(0, 1, LD,  1, 0, 0), vo(3, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        add("ld_m2",  vi(0, 1, LD,  1, 0, 0), vo(3, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        add("ld_m3",  vi(0, 1, LD,  1, 0, 1), vo(3, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        add("ld_w",   vi(0, 1, LD,  1, 0, 0), vo(4, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        add("ld_r",   vi(0, 0, LD,  1, 0, 0), vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        // Store then branch back to back
        add("st_f",   vi(0, 1, ST,  0, 1, 0), vo(0, 1, 1, 0, 0, 0, 0, 0, 0, 2));
        add("st_d",   vi(0, 1, ST,  0, 0, 0), vo(1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        add("st_e",   vi(0, 1, ST,  0, 0, 0), vo(2, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        add("st_m",   vi(0, 1, ST,  0, 0, 1), vo(3, 0, 0, 1, 1, 1, 0, 0, 0, 2));
        add("br_f",   vi(0, 1, BR,  0, 1, 0), vo(0, 1, 1, 0, 0, 0, 0, 0, 0, 3));
        add("br_d",   vi(0, 1, BR,  0, 0, 1), vo(1, 0, 0, 0, 0, 0, 0, 0, 0, 3));
        add("br_e",   vi(0, 1, BR,  0, 0, 1), vo(2, 0, 0, 0, 0, 1, 0, 0, 0, 3));
        add("br_r",   vi(0, 0, BR,  0, 0, 0), vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
        // imem_ack without a request is ignored
        add("idle0",  vi(0, 0, ALU, 1, 1, 0), vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
        add("idle1",  vi(0, 0, ALU, 1, 1, 0), vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
        // run dropped mid-instruction; wb_reg=0 gives no reg_we
        add("lui_f",  vi(0, 1, LUI, 0, 1, 0), vo(0, 1, 1, 0, 0, 0, 0, 0, 0, 4));
        add("lui_d",  vi(0, 0, LUI, 0, 0, 0), vo(1, 0, 0, 0, 0, 0, 0, 0, 0, 4));
        add("lui_e",  vi(0, 0, LUI, 0, 0, 0), vo(2, 0, 0, 0, 0, 0, 0, 0, 0, 4));
        add("lui_w",  vi(0, 0, LUI, 0, 0, 0), vo(4, 0, 0, 0, 0, 1, 0, 0, 0, 4));
        add("lui_r",  vi(0, 0, LUI, 0, 1, 0), vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 5));
        // Reset mid-MEM with dmem_req high
        add("rm_f",   vi(0, 1, LD,  1, 1, 0), vo(0, 1, 1, 0, 0, 0, 0, 0, 0, 5));
        add("rm_d",   vi(0, 1, LD,  1, 0, 0), vo(1, 0, 0, 0, 0, 0, 0, 0, 0, 5));
        add("rm_e",   vi(0, 1, LD,  1, 0, 0), vo(2, 0, 0, 0, 0, 0, 0, 0, 0, 5));
        add("rm_m",   vi(0, 1, LD,  1, 0, 0), vo(3, 0, 0, 1, 0, 0, 0, 0, 0, 5));
        add("rm_rst", vi(1, 1, LD,  1, 0, 1), vo(3, 0, 0, 0, 0, 0, 0, 0, 0, 5));
        add("rm_post",vi(0, 0, LD,  1, 0, 0), vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[k]) step(tbl[k].nm, tbl[k].i, tbl[k].o);

        // Illegal opcode: HALT ignores run and acks until reset
        step("il_f",  vi(0, 1, BAD, 1, 1, 0), vo(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        step("il_d",  vi(0, 1, BAD, 1, 0, 0), vo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++)
            step("il_halt", vi(0, k % 2, BAD, 1, 1, k % 2), vo(5, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        step("il_rst",  vi(1, 1, BAD, 1, 1, 0), vo(5, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        step("il_post", vi(0, 0, ALU, 1, 0, 0), vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Fetch timeout: 4 request cycles without ack, then HALT with bus_err
        for (int k = 0; k < MT; k++)
            step("to_if", vi(0, 1, LD, 1, 0, 0), vo(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        step("to_if_halt", vi(0, 1, LD, 1, 1, 1), vo(5, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step("to_rst",     vi(1, 1, LD, 1, 0, 0), vo(5, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        // Ack on the last allowed cycle wins
        for (int k = 0; k < MT - 1; k++)
            step("ack_last_w", vi(0, 1, LD, 1, 0, 0), vo(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        step("ack_last",   vi(0, 1, LD, 1, 1, 0), vo(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        step("ack_last_d", vi(0, 1, LD, 1, 0, 0), vo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("ack_last_e", vi(0, 1, LD, 1, 0, 0), vo(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Data memory timeout
        for (int k = 0; k < MT; k++)
            step("to_dm", vi(0, 1, LD, 1, 0, 0), vo(3, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        step("to_dm_halt", vi(0, 1, LD, 1, 0, 1), vo(5, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
